// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Purpose: tracks in-flight writers to each architectural register and
// decides whether an issue request can go this cycle. Every register has a
// small pending-write counter. A fired request adds one to each register it
// claims as a destination. Each writeback port that names a register takes
// one away again.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   req_valid      issue request present
//   req_src_en     per-source-port enable            [NSRC]
//   req_src_idx    source indices, packed            [NSRC*IDX_W]
//   req_dst_en     per-destination-port enable       [NDST]
//   req_dst_idx    destination indices, packed       [NDST*IDX_W]
//   req_ready      combinational: request may issue this cycle
//   wb_en          per-writeback-port release        [NWB]
//   wb_idx         released register indices, packed [NWB*IDX_W]
//   flush          discard all in-flight claims
//   busy_vec       registered: bit r set while register r has writers pending
//   err_underflow  sticky: release seen on a register with nothing pending
//   err_overflow   sticky: claim fired on a saturated counter
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NREGS     = 33,
  parameter int IDX_W     = 6,
  parameter int CNT_W     = 2,
  parameter int NSRC      = 3,
  parameter int NDST      = 2,
  parameter int NWB       = 2,
  parameter int WB_BYPASS = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [NSRC-1:0]        req_src_en,
  input  logic [NSRC*IDX_W-1:0]  req_src_idx,
  input  logic [NDST-1:0]        req_dst_en,
  input  logic [NDST*IDX_W-1:0]  req_dst_idx,
  output logic                   req_ready,
  input  logic [NWB-1:0]         wb_en,
  input  logic [NWB*IDX_W-1:0]   wb_idx,
  input  logic                   flush,
  output logic [NREGS-1:0]       busy_vec,
  output logic                   err_underflow,
  output logic                   err_overflow
);

  // DEC_W holds a release count of 0..NWB.
  // SUM_W holds count + inc without wrapping.
  localparam int DEC_W = $clog2(NWB + 1);
  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [DEC_W-1:0] dec   [NREGS];
  logic [NREGS-1:0] src_hit;
  logic [NREGS-1:0] dst_hit;
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             err_underflow_q;
  logic             err_underflow_d;
  logic             err_overflow_q;
  logic             err_overflow_d;
  logic             fire;

  // Per-register decode of the request and writeback ports. Each register
  // is compared only against itself, so an index >= NREGS never matches.
  // That index is therefore ignored. Duplicate destinations collapse into
  // a single hit, so one request claims a register at most once.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      src_hit[r] = 1'b0;
      dst_hit[r] = 1'b0;
      dec[r]     = '0;
      for (int k = 0; k < NSRC; k++) begin
        if (req_src_en[k] && (req_src_idx[k*IDX_W +: IDX_W] == IDX_W'(r)))
          src_hit[r] = 1'b1;
      end
      for (int k = 0; k < NDST; k++) begin
        if (req_dst_en[k] && (req_dst_idx[k*IDX_W +: IDX_W] == IDX_W'(r)))
          dst_hit[r] = 1'b1;
      end
      for (int k = 0; k < NWB; k++) begin
        if (wb_en[k] && (wb_idx[k*IDX_W +: IDX_W] == IDX_W'(r)))
          dec[r] = dec[r] + DEC_W'(1);
      end
    end
  end

  // Issue check. A RAW hazard on any source stalls the request. So does a
  // destination whose counter is already full. With bypass enabled, a
  // source is free when every pending writer retires this very cycle.
  // req_valid is deliberately absent here. That keeps valid/ready free of
  // a combinational loop.
  always_comb begin
    req_ready = !flush;
    for (int r = 0; r < NREGS; r++) begin
      if (src_hit[r]) begin
        if (WB_BYPASS != 0) begin
          if (SUM_W'(cnt_q[r]) != SUM_W'(dec[r]))
            req_ready = 1'b0;
        end else if (cnt_q[r] != '0) begin
          req_ready = 1'b0;
        end
      end
      if (dst_hit[r] && (cnt_q[r] == CNT_MAX))
        req_ready = 1'b0;
    end
  end

  assign fire = req_valid && req_ready;

  // Counter update: count + inc - dec.
  //   - Flush wins over everything else and raises no errors.
  //   - A release that would drive a count below zero clamps it to zero
  //     and flags err_underflow.
  //   - The overflow checks cannot trigger while the stall logic holds.
  //     They stay as a guard against protocol breakage.
  always_comb begin
    logic [SUM_W-1:0] sum;
    sum             = '0;
    err_underflow_d = err_underflow_q;
    err_overflow_d  = err_overflow_q;
    for (int r = 0; r < NREGS; r++) begin
      sum = SUM_W'(cnt_q[r]) + SUM_W'(fire && dst_hit[r]);
      if (!flush && fire && dst_hit[r] && (cnt_q[r] == CNT_MAX))
        err_overflow_d = 1'b1;
      if (flush) begin
        cnt_d[r] = '0;
      end else if (sum < SUM_W'(dec[r])) begin
        cnt_d[r]        = '0;
        err_underflow_d = 1'b1;
      end else begin
        sum = sum - SUM_W'(dec[r]);
        if (sum > SUM_W'(CNT_MAX)) begin
          cnt_d[r]       = CNT_MAX;
          err_overflow_d = 1'b1;
        end else begin
          cnt_d[r] = sum[CNT_W-1:0];
        end
      end
      busy_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= '0;
      busy_q          <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        cnt_q[r] <= cnt_d[r];
      busy_q          <= busy_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign busy_vec      = busy_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Purpose: directed bench for reg_scoreboard with its default parameters.
// Two instances share every input:
//   - dut     : writeback bypass disabled
//   - dut_byp : writeback bypass enabled
// Whenever the two instances could disagree on req_ready, req_valid is
// held low, so their internal state always stays identical.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_src_en;
  logic [17:0] req_src_idx;
  logic [1:0]  req_dst_en;
  logic [11:0] req_dst_idx;
  logic        req_ready;
  logic [1:0]  wb_en;
  logic [11:0] wb_idx;
  logic        flush;
  logic [32:0] busy_vec;
  logic        err_underflow;
  logic        err_overflow;
  logic        b_req_ready;
  logic [32:0] b_busy_vec;
  logic        b_err_underflow;
  logic        b_err_overflow;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_src_en(req_src_en), .req_src_idx(req_src_idx),
    .req_dst_en(req_dst_en), .req_dst_idx(req_dst_idx),
    .req_ready(req_ready), .wb_en(wb_en), .wb_idx(wb_idx),
    .flush(flush), .busy_vec(busy_vec),
    .err_underflow(err_underflow), .err_overflow(err_overflow)
  );

  reg_scoreboard #(.WB_BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_src_en(req_src_en), .req_src_idx(req_src_idx),
    .req_dst_en(req_dst_en), .req_dst_idx(req_dst_idx),
    .req_ready(b_req_ready), .wb_en(wb_en), .wb_idx(wb_idx),
    .flush(flush), .busy_vec(b_busy_vec),
    .err_underflow(b_err_underflow), .err_overflow(b_err_overflow)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    test_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] src_en,
                               input logic [5:0] s0, input logic [5:0] s1,
                               input logic [5:0] s2, input logic [1:0] dst_en,
                               input logic [5:0] d0, input logic [5:0] d1,
                               input logic [1:0] wben, input logic [5:0] w0,
                               input logic [5:0] w1, input logic fl);
    req_valid   = valid;
    req_src_en  = src_en;
    req_src_idx = {s2, s1, s0};
    req_dst_en  = dst_en;
    req_dst_idx = {d1, d0};
    wb_en       = wben;
    wb_idx      = {w1, w0};
    flush       = fl;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("rst_busy", 64'(busy_vec), 64'h0);
    checkOutput("rst_unf", 64'(err_underflow), 64'h0);
    checkOutput("rst_ovf", 64'(err_overflow), 64'h0);
    checkOutput("rst_ready", 64'(req_ready), 64'h1);
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    checkOutput("rst_flush_ready", 64'(req_ready), 64'h0);
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Claim reg 0, then a RAW stall on it; the release is bypassed only in dut_byp
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("claim0_ready", 64'(req_ready), 64'h1);
    tick();
    checkOutput("claim0_busy", 64'(busy_vec), 64'h1);
    applyStimulus(1, 3'b001, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("raw_ready", 64'(req_ready), 64'h0);
    checkOutput("raw_ready_byp", 64'(b_req_ready), 64'h0);
    applyStimulus(0, 3'b001, 0, 0, 0, 2'b00, 0, 0, 2'b01, 0, 0, 0);
    checkOutput("wb0_ready", 64'(req_ready), 64'h0);
    checkOutput("wb0_ready_byp", 64'(b_req_ready), 64'h1);
    tick();
    checkOutput("wb0_busy", 64'(busy_vec), 64'h0);
    applyStimulus(0, 3'b001, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("after_wb0_ready", 64'(req_ready), 64'h1);
    checkOutput("after_wb0_ready_byp", 64'(b_req_ready), 64'h1);

    // Saturate reg 7 with three claims, then release
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b00, 0, 0, 0);
      checkOutput("sat_claim_ready", 64'(req_ready), 64'h1);
      tick();
    end
    checkOutput("sat_busy", 64'(busy_vec), 64'h80);
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b00, 0, 0, 0);
    checkOutput("sat_stall", 64'(req_ready), 64'h0);
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b01, 7, 0, 0);
    checkOutput("sat_stall_wb", 64'(req_ready), 64'h0);
    checkOutput("sat_stall_wb_byp", 64'(b_req_ready), 64'h0);
    tick();
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b00, 0, 0, 0);
    checkOutput("sat_release_ready", 64'(req_ready), 64'h1);
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 7, 7, 0);
    tick();
    checkOutput("sat_drain_busy", 64'(busy_vec), 64'h0);
    checkOutput("sat_drain_unf", 64'(err_underflow), 64'h0);

    // Fire and release netting on reg 5, then a double release
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
    tick();
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b01, 5, 0, 0);
    checkOutput("net_ready", 64'(req_ready), 64'h1);
    tick();
    checkOutput("net_busy", 64'(busy_vec), 64'h20);
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
    tick();
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 5, 5, 0);
    tick();
    checkOutput("dual_wb_busy", 64'(busy_vec), 64'h0);
    checkOutput("dual_wb_unf", 64'(err_underflow), 64'h0);

    // Duplicate destination claims once; out-of-range indices are ignored
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b11, 3, 3, 2'b00, 0, 0, 0);
    tick();
    checkOutput("dup_busy", 64'(busy_vec), 64'h8);
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 3, 0, 0);
    tick();
    checkOutput("dup_single_release", 64'(busy_vec), 64'h0);
    applyStimulus(1, 3'b001, 40, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("oor_src_ready", 64'(req_ready), 64'h1);
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 40, 0, 2'b01, 40, 0, 0);
    tick();
    checkOutput("oor_dst_busy", 64'(busy_vec), 64'h0);
    checkOutput("oor_wb_unf", 64'(err_underflow), 64'h0);

    // Claims on 0, 2, 4, then flush with a concurrent fire and releases
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b11, 0, 2, 2'b00, 0, 0, 0);
    tick();
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 4, 0, 2'b00, 0, 0, 0);
    tick();
    checkOutput("multi_busy", 64'(busy_vec), 64'h15);
    applyStimulus(1, 3'b100, 0, 0, 2, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("raw_port2", 64'(req_ready), 64'h0);
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 6, 0, 2'b11, 2, 11, 1);
    checkOutput("flush_ready", 64'(req_ready), 64'h0);
    tick();
    checkOutput("flush_busy", 64'(busy_vec), 64'h0);
    checkOutput("flush_unf", 64'(err_underflow), 64'h0);
    checkOutput("flush_ovf", 64'(err_overflow), 64'h0);

    // Underflow on idle reg 9 is sticky through flush
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 9, 0, 0);
    tick();
    checkOutput("unf_set", 64'(err_underflow), 64'h1);
    checkOutput("unf_set_byp", 64'(b_err_underflow), 64'h1);
    checkOutput("unf_busy", 64'(busy_vec), 64'h0);
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    tick();
    checkOutput("unf_after_flush", 64'(err_underflow), 64'h1);

    // Asynchronous reset in mid-cycle, then the first claim after it
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 1, 0, 2'b00, 0, 0, 0);
    tick();
    checkOutput("pre_reset_busy", 64'(busy_vec), 64'h2);
    applyStimulus(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_busy", 64'(busy_vec), 64'h0);
    checkOutput("async_rst_unf", 64'(err_underflow), 64'h0);
    checkOutput("async_rst_ovf", 64'(err_overflow), 64'h0);
    checkOutput("async_rst_ready", 64'(req_ready), 64'h1);
    #1;
    reset = 1'b1;
    applyStimulus(1, 3'b000, 0, 0, 0, 2'b01, 8, 0, 2'b00, 0, 0, 0);
    tick();
    checkOutput("post_rst_busy", 64'(busy_vec), 64'h100);
    checkOutput("post_rst_busy_byp", 64'(b_busy_vec), 64'h100);
    applyStimulus(0, 3'b001, 8, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    checkOutput("post_rst_raw", 64'(req_ready), 64'h0);
    checkOutput("final_ovf_byp", 64'(b_err_overflow), 64'h0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
